// File: rtl/eager_fork_pkg.sv
// Shared handshake package used by the fork, join and merge units.
// Contents:
//   HS_MAX_SIZE    - largest legal channel count of a multi-channel unit
//   hs_chan_width  - physical payload width of a channel; a dataless
//                    (DATA_WIDTH == 0) channel still carries a 1-bit port
package eager_fork_pkg;

  localparam int HS_MAX_SIZE = 32;

  // Dataless channels keep a 1-bit payload port so port lists stay uniform.
  function automatic int hs_chan_width(input int data_width);
    if (data_width == 0) begin
      return 1;
    end else begin
      return data_width;
    end
  endfunction

endpackage

// File: rtl/eager_fork_register_block.sv
// Per-output tracking slice of the eager fork.
// Remembers whether this output has already taken the current token, so the
// output is never offered the same token twice.
// Ports:
//   clk, rst    - clock and asynchronous active-low reset
//   ins_valid   - upstream token present
//   outs_ready  - this output's ready
//   fire        - the input token is consumed this cycle
//   outs_valid  - this output's valid
//   done        - this output has taken, or is taking, the current token
module eager_fork_register_block (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  input  logic outs_ready,
  input  logic fire,
  output logic outs_valid,
  output logic done
);

  logic sent_r;

  assign outs_valid = ins_valid & ~sent_r;
  assign done       = sent_r | outs_ready;

  // Sent flag: set on this output's transfer, cleared once the whole token is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_r <= 1'b0;
    end else if (fire) begin
      sent_r <= 1'b0;
    end else begin
      sent_r <= sent_r | (outs_valid & outs_ready);
    end
  end

endmodule

// File: rtl/eager_fork.sv
// Eager fork: replicates one input token onto SIZE output channels. Each
// output may take its copy in a different cycle; the input is consumed in the
// cycle the last outstanding output accepts. No payload storage, zero-latency
// forward path; outs_ready -> ins_ready is combinational by design.
// Ports:
//   clk, rst    - clock and asynchronous active-low reset
//   ins         - input payload (1 bit wide and ignored when DATA_WIDTH == 0)
//   ins_valid   - input token present
//   ins_ready   - input consumed this cycle when ins_valid is also high
//   outs        - SIZE copies of ins; slice i is output i
//   outs_valid  - per-output valid
//   outs_ready  - per-output ready
//   stall_cnt   - (EAGER_FORK_STALL_CNT_EN only) saturating count of cycles
//                 with ins_valid high and ins_ready low
// Optional feature macro: EAGER_FORK_STALL_CNT_EN
module eager_fork
  import eager_fork_pkg::*;
#(
  parameter int SIZE       = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [hs_chan_width(DATA_WIDTH)-1:0]      ins,
  input  logic                                     ins_valid,
  output logic                                     ins_ready,
  output logic [SIZE*hs_chan_width(DATA_WIDTH)-1:0] outs,
  output logic [SIZE-1:0]                          outs_valid,
  input  logic [SIZE-1:0]                          outs_ready
`ifdef EAGER_FORK_STALL_CNT_EN
  ,
  output logic [31:0]                              stall_cnt
`endif
);

  if ((SIZE < 1) || (SIZE > HS_MAX_SIZE)) begin : g_bad_size
    $error("eager_fork: SIZE out of range");
  end

  logic [SIZE-1:0] done_s;
  logic            fire_s;

  assign outs      = {SIZE{ins}};
  assign ins_ready = &done_s;
  assign fire_s    = ins_valid & ins_ready;

  for (genvar i = 0; i < SIZE; i++) begin : g_out
    eager_fork_register_block u_reg (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .outs_ready (outs_ready[i]),
      .fire       (fire_s),
      .outs_valid (outs_valid[i]),
      .done       (done_s[i])
    );
  end

`ifdef EAGER_FORK_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Profiling counter: cycles a token waits on at least one output, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
    end else if (ins_valid && !ins_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule
